// File: rtl/branch_issue_ctrl_pkg.sv
// Shared types for the branch issue path: funct3 codes, controller states and
// the resolved-branch record broadcast on the CDB.
package branch_issue_ctrl_pkg;

  localparam int XLEN = 32;
  // Tag field is sized for the widest ROB; instances use the low TAG_W bits.
  localparam int BR_TAG_W_MAX = 16;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } BR_FUNC;

  typedef enum logic [1:0] {
    BR_IDLE  = 2'd0,
    BR_EXEC  = 2'd1,
    BR_BCAST = 2'd2
  } BR_CTRL_STATE;

  typedef struct packed {
    logic [BR_TAG_W_MAX-1:0] tag;
    logic                    taken;
    logic [XLEN-1:0]         redirect_pc;
    logic                    mispredict;
  } BR_RESULT;

endpackage

// File: rtl/branch_unit.sv
// Branch condition evaluator plus taken / fall-through target adders.
module branch_unit
  import branch_issue_ctrl_pkg::*;
(
  input  logic [2:0]      func,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            cond,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] fall_pc
);

  assign target  = pc + imm;
  assign fall_pc = pc + XLEN'(4);

  always_comb begin
    cond = 1'b0;
    case (func)
      BR_BEQ:  cond = (rs1 == rs2);
      BR_BNE:  cond = (rs1 != rs2);
      BR_BLT:  cond = ($signed(rs1) <  $signed(rs2));
      BR_BGE:  cond = ($signed(rs1) >= $signed(rs2));
      BR_BLTU: cond = (rs1 <  rs2);
      BR_BGEU: cond = (rs1 >= rs2);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: search begins at ptr, first requester wins and
// the next pointer lands just past the winner.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic [PTR_W-1:0] next_ptr,
  output logic             any
);

  always_comb begin
    int idx;
    gnt      = '0;
    gnt_idx  = '0;
    next_ptr = ptr;
    any      = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PTR_W'(idx);
        next_ptr = PTR_W'((idx + 1) % N);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_issue_ctrl.sv
// Issues branch RS entries to the shared branch unit and holds each result on
// the CDB until accepted. Optional counters: define BRANCH_STATS_EN.
module branch_issue_ctrl
  import branch_issue_ctrl_pkg::*;
#(
  parameter int N_RS  = 4,
  parameter int TAG_W = 5
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic [N_RS-1:0]                  rs_req,
  input  logic [N_RS-1:0][XLEN-1:0]        rs_rs1,
  input  logic [N_RS-1:0][XLEN-1:0]        rs_rs2,
  input  logic [N_RS-1:0][2:0]             rs_func,
  input  logic [N_RS-1:0][XLEN-1:0]        rs_pc,
  input  logic [N_RS-1:0][XLEN-1:0]        rs_imm,
  input  logic [N_RS-1:0]                  rs_pred_taken,
  input  logic [N_RS-1:0][XLEN-1:0]        rs_pred_target,
  input  logic [N_RS-1:0][TAG_W-1:0]       rs_tag,
  output logic [N_RS-1:0]                  rs_gnt,
  output logic                             cdb_req,
  input  logic                             cdb_gnt,
  output logic [TAG_W-1:0]                 cdb_tag,
  output logic                             cdb_taken,
  output logic [XLEN-1:0]                  cdb_redirect_pc,
  output logic                             cdb_mispredict,
  output logic                             busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]                      stat_resolved,
  output logic [31:0]                      stat_mispredict
`endif
);

  localparam int PTR_W = $clog2(N_RS);

  BR_CTRL_STATE     state_q;
  logic [PTR_W-1:0] rr_ptr_q;

  logic [N_RS-1:0]  arb_gnt;
  logic [PTR_W-1:0] arb_idx, arb_next_ptr;
  logic             arb_any;
  logic             grant_en;

  logic             op_vld_q;
  logic [XLEN-1:0]  op_rs1_q, op_rs2_q, op_pc_q, op_imm_q, op_pred_target_q;
  logic [2:0]       op_func_q;
  logic             op_pred_taken_q;
  logic [TAG_W-1:0] op_tag_q;

  logic             res_vld_q;
  BR_RESULT         res_q, res_d;

  logic             bu_cond;
  logic [XLEN-1:0]  bu_target, bu_fall;

  rr_arbiter #(.N(N_RS), .PTR_W(PTR_W)) u_arb (
    .req      (rs_req),
    .ptr      (rr_ptr_q),
    .gnt      (arb_gnt),
    .gnt_idx  (arb_idx),
    .next_ptr (arb_next_ptr),
    .any      (arb_any)
  );

  branch_unit u_bu (
    .func    (op_func_q),
    .rs1     (op_rs1_q),
    .rs2     (op_rs2_q),
    .pc      (op_pc_q),
    .imm     (op_imm_q),
    .cond    (bu_cond),
    .target  (bu_target),
    .fall_pc (bu_fall)
  );

  // A slot opens only when the unit is empty or the held result leaves this cycle.
  assign grant_en = !squash && arb_any &&
                    ((state_q == BR_IDLE) || ((state_q == BR_BCAST) && cdb_gnt));
  assign rs_gnt   = grant_en ? arb_gnt : '0;

  always_comb begin
    res_d             = '0;
    res_d.tag         = BR_TAG_W_MAX'(op_tag_q);
    res_d.taken       = bu_cond;
    res_d.redirect_pc = bu_cond ? bu_target : bu_fall;
    res_d.mispredict  = (bu_cond != op_pred_taken_q) |
                        (bu_cond & op_pred_taken_q & (bu_target != op_pred_target_q));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= BR_IDLE;
      rr_ptr_q         <= '0;
      op_vld_q         <= 1'b0;
      op_rs1_q         <= '0;
      op_rs2_q         <= '0;
      op_func_q        <= '0;
      op_pc_q          <= '0;
      op_imm_q         <= '0;
      op_pred_taken_q  <= 1'b0;
      op_pred_target_q <= '0;
      op_tag_q         <= '0;
      res_vld_q        <= 1'b0;
      res_q            <= '0;
    end else begin
      if (grant_en) begin
        op_vld_q         <= 1'b1;
        op_rs1_q         <= rs_rs1[arb_idx];
        op_rs2_q         <= rs_rs2[arb_idx];
        op_func_q        <= rs_func[arb_idx];
        op_pc_q          <= rs_pc[arb_idx];
        op_imm_q         <= rs_imm[arb_idx];
        op_pred_taken_q  <= rs_pred_taken[arb_idx];
        op_pred_target_q <= rs_pred_target[arb_idx];
        op_tag_q         <= rs_tag[arb_idx];
        rr_ptr_q         <= arb_next_ptr;
      end
      if (squash) begin
        // A concurrent cdb_gnt still retires the held result; it is simply dropped here.
        state_q   <= BR_IDLE;
        op_vld_q  <= 1'b0;
        res_vld_q <= 1'b0;
      end else begin
        case (state_q)
          BR_IDLE: if (grant_en) state_q <= BR_EXEC;
          BR_EXEC: begin
            res_q     <= res_d;
            res_vld_q <= op_vld_q;
            op_vld_q  <= 1'b0;
            state_q   <= BR_BCAST;
          end
          BR_BCAST: if (cdb_gnt) begin
            res_vld_q <= 1'b0;
            state_q   <= grant_en ? BR_EXEC : BR_IDLE;
          end
          default: state_q <= BR_IDLE;
        endcase
      end
    end
  end

  assign cdb_req         = res_vld_q;
  assign cdb_tag         = res_q.tag[TAG_W-1:0];
  assign cdb_taken       = res_q.taken;
  assign cdb_redirect_pc = res_q.redirect_pc;
  assign cdb_mispredict  = res_q.mispredict;
  assign busy            = (state_q != BR_IDLE);

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_resolved_q, stat_mispredict_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_resolved_q   <= '0;
      stat_mispredict_q <= '0;
    end else if (cdb_req && cdb_gnt) begin
      if (stat_resolved_q != '1)
        stat_resolved_q <= stat_resolved_q + 32'd1;
      if (cdb_mispredict && (stat_mispredict_q != '1))
        stat_mispredict_q <= stat_mispredict_q + 32'd1;
    end
  end

  assign stat_resolved   = stat_resolved_q;
  assign stat_mispredict = stat_mispredict_q;
`endif

endmodule

// File: tb/tb_branch_issue_ctrl.sv
// Directed bench for branch_issue_ctrl: reset, single issue, round-robin,
// CDB stall, squash and PC wrap.
module tb_branch_issue_ctrl;

  logic              clock = 1'b0;
  logic              reset, squash, cdb_gnt;
  logic [3:0]        rs_req, rs_pred_taken, rs_gnt;
  logic [3:0][31:0]  rs_rs1, rs_rs2, rs_pc, rs_imm, rs_pred_target;
  logic [3:0][2:0]   rs_func;
  logic [3:0][4:0]   rs_tag;
  logic              cdb_req, cdb_taken, cdb_mispredict, busy;
  logic [4:0]        cdb_tag;
  logic [31:0]       cdb_redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0]       stat_resolved, stat_mispredict;
`endif

  int ntests = 0;
  int nfail  = 0;

  always #5 clock = ~clock;

  branch_issue_ctrl #(.N_RS(4), .TAG_W(5)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .rs_req(rs_req), .rs_rs1(rs_rs1), .rs_rs2(rs_rs2), .rs_func(rs_func),
    .rs_pc(rs_pc), .rs_imm(rs_imm), .rs_pred_taken(rs_pred_taken),
    .rs_pred_target(rs_pred_target), .rs_tag(rs_tag), .rs_gnt(rs_gnt),
    .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .cdb_tag(cdb_tag),
    .cdb_taken(cdb_taken), .cdb_redirect_pc(cdb_redirect_pc),
    .cdb_mispredict(cdb_mispredict), .busy(busy)
`ifdef BRANCH_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_res(input string n, input logic [4:0] tg, input logic tk,
                         input logic [31:0] rd, input logic mis);
    chk({n, ".req"},  cdb_req, 1);
    chk({n, ".tag"},  cdb_tag, tg);
    chk({n, ".taken"}, cdb_taken, tk);
    chk({n, ".redir"}, cdb_redirect_pc, rd);
    chk({n, ".mis"},  cdb_mispredict, mis);
  endtask

  task automatic set_ent(input int i, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptg, input logic [4:0] tg);
    rs_func[i] = f; rs_rs1[i] = a; rs_rs2[i] = b; rs_pc[i] = pc; rs_imm[i] = imm;
    rs_pred_taken[i] = pt; rs_pred_target[i] = ptg; rs_tag[i] = tg;
  endtask

  initial begin
    reset = 1'b1; squash = 1'b0; cdb_gnt = 1'b0; rs_req = '0;
    rs_rs1 = '0; rs_rs2 = '0; rs_pc = '0; rs_imm = '0; rs_pred_target = '0;
    rs_func = '0; rs_tag = '0; rs_pred_taken = '0;
    repeat (2) cyc();
    reset = 1'b0;
    #1;
    chk("rst.req", cdb_req, 0);
    chk("rst.tag", cdb_tag, 0);
    chk("rst.taken", cdb_taken, 0);
    chk("rst.redir", cdb_redirect_pc, 0);
    chk("rst.mis", cdb_mispredict, 0);
    chk("rst.busy", busy, 0);
    chk("rst.gnt", rs_gnt, 0);
    cyc();
    chk("idle.busy", busy, 0);
    chk("idle.gnt", rs_gnt, 0);

    // single BEQ from entry 2
    set_ent(2, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120, 5'd7);
    rs_req = 4'b0100;
    #1 chk("s2.gnt", rs_gnt, 4'b0100);
    cyc(); rs_req = 4'b0000;
    #1;
    chk("s2.exec.busy", busy, 1);
    chk("s2.exec.req", cdb_req, 0);
    chk("s2.exec.gnt", rs_gnt, 0);
    cyc();
    chk_res("s2", 5'd7, 1'b1, 32'h120, 1'b0);
    cdb_gnt = 1'b1;
    cyc(); cdb_gnt = 1'b0;
    #1;
    chk("s2.done.req", cdb_req, 0);
    chk("s2.done.busy", busy, 0);

    // fresh reset so the pointer restarts at entry 0
    reset = 1'b1; cyc(); reset = 1'b0;
    set_ent(0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1, 32'h240, 5'd10);
    set_ent(1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b1, 32'h340, 5'd11);
    set_ent(2, 3'b101, 32'd3, 32'd3, 32'h400, 32'hFFFF_FFF0, 1'b0, 32'h0, 5'd12);
    set_ent(3, 3'b111, 32'd1, 32'hFFFF_FFFF, 32'h500, 32'h8, 1'b0, 32'h0, 5'd13);
    rs_req = 4'hF; cdb_gnt = 1'b1;
    #1 chk("rr.g0", rs_gnt, 4'b0001);
    cyc();
    chk("rr.exec.gnt", rs_gnt, 0);
    chk("rr.exec.req", cdb_req, 0);
    cyc();
    chk_res("rr0", 5'd10, 1'b1, 32'h240, 1'b0);
    chk("rr.g1", rs_gnt, 4'b0010);
    rs_pred_target[0] = 32'h999;
    cyc(); cyc();
    chk_res("rr1", 5'd11, 1'b0, 32'h304, 1'b1);
    chk("rr.g2", rs_gnt, 4'b0100);
    cyc(); cyc();
    chk_res("rr2", 5'd12, 1'b1, 32'h3F0, 1'b1);
    chk("rr.g3", rs_gnt, 4'b1000);
    cyc(); cyc();
    chk_res("rr3", 5'd13, 1'b0, 32'h504, 1'b0);
    chk("rr.g0b", rs_gnt, 4'b0001);
    cyc(); cyc();
    chk_res("rr0b", 5'd10, 1'b1, 32'h240, 1'b1);

    // CDB back-pressure
    cdb_gnt = 1'b0;
    #1 chk("stall.gnt", rs_gnt, 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk_res($sformatf("stall%0d", k), 5'd10, 1'b1, 32'h240, 1'b1);
      chk($sformatf("stall%0d.gnt", k), rs_gnt, 0);
    end
    cdb_gnt = 1'b1;
    #1 chk("stall.rel.gnt", rs_gnt, 4'b0010);

    // squash during EXEC, pointer retained
    cyc();
    squash = 1'b1;
    #1 chk("sq.exec.gnt", rs_gnt, 0);
    cyc(); squash = 1'b0;
    #1;
    chk("sq.req", cdb_req, 0);
    chk("sq.busy", busy, 0);
    chk("sq.ptr.gnt", rs_gnt, 4'b0100);
    cyc(); cyc();
    chk_res("rr2b", 5'd12, 1'b1, 32'h3F0, 1'b1);

    // squash together with cdb_gnt in BCAST
    squash = 1'b1;
    #1 chk("sqg.gnt", rs_gnt, 0);
    cyc(); squash = 1'b0; rs_req = '0; cdb_gnt = 1'b0;
    #1;
    chk("sqg.busy", busy, 0);
    chk("sqg.req", cdb_req, 0);

    // BNE with PC wrap
    set_ent(1, 3'b001, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h20, 1'b0, 32'h0, 5'd21);
    rs_req = 4'b0010; cdb_gnt = 1'b1;
    #1 chk("bne.gnt", rs_gnt, 4'b0010);
    cyc(); rs_req = '0;
    cyc();
    chk_res("bne", 5'd21, 1'b1, 32'h10, 1'b1);
    cyc();
    chk("bne.done.busy", busy, 0);
`ifdef BRANCH_STATS_EN
    chk("stat.resolved", stat_resolved, 7);
    chk("stat.mispredict", stat_mispredict, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/branch_issue_ctrl.md
# branch_issue_ctrl

Sequences the shared branch unit among `N_RS` branch reservation-station entries in the Tomasulo core. Each cycle it round-robin arbitrates ready entries, latches the winner's operands, and evaluates condition and target through one `branch_unit` instance. It then holds the resolved result until the CDB accepts it. It produces the redirect PC and the mispredict flag that the ROB uses for recovery.

## Interface
Parameters:
- `N_RS`, 4: number of branch RS entries (requesters), ≥2
- `TAG_W`, 5: ROB tag width

Ports:
- `clock` in 1: single clock, all state on posedge
- `reset` in 1: synchronous, active-high
- `squash` in 1: pipeline flush from ROB, synchronous
- `rs_req` in N_RS: entry i ready (operands valid)
- `rs_rs1`, `rs_rs2` in N_RS×XLEN: compare operands
- `rs_func` in N_RS×3: funct3 (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111)
- `rs_pc`, `rs_imm` in N_RS×XLEN: branch PC, sign-extended B-immediate
- `rs_pred_taken` in N_RS: predicted direction
- `rs_pred_target` in N_RS×XLEN: predicted target
- `rs_tag` in N_RS×TAG_W: ROB tag
- `rs_gnt` out N_RS: one-hot grant; entry frees itself on the same edge
- `cdb_req` out 1: result valid, requesting CDB
- `cdb_gnt` in 1: CDB accepts this cycle
- `cdb_tag` out TAG_W; `cdb_taken` out 1; `cdb_redirect_pc` out XLEN; `cdb_mispredict` out 1
- `busy` out 1: state ≠ IDLE

## Operation
- FSM states:
  - IDLE: if `|rs_req`, assert `rs_gnt` for the winner combinationally, latch its fields into the operand register, then go to EXEC.
  - EXEC: the operand register drives `branch_unit`. Register cond, target, tag and prediction into the result register, then go to BCAST.
  - BCAST: `cdb_req`=1 with outputs from the result register. Stay until `cdb_gnt`. On `cdb_gnt` with `|rs_req`, grant the next entry in the same cycle and go to EXEC. On `cdb_gnt` with no request, go to IDLE.
- Grants are possible only in IDLE, or in BCAST with `cdb_gnt`. `rs_gnt` is 0 otherwise.
- Arbitration: round-robin. Search starts at `rr_ptr`. After granting i, `rr_ptr` ← (i+1) mod N_RS, wrapping N_RS−1→0.
- `cdb_taken` = cond.
- `cdb_redirect_pc` = cond ? pc+imm : pc+4. All adds are XLEN-bit modulo; carry is dropped.
- `cdb_mispredict` = (cond ≠ pred_taken) | (cond & pred_taken & (pc+imm ≠ pred_target)).
- Signed compares for BLT/BGE; unsigned for BLTU/BGEU. Undefined funct3 gives cond=0.
- `squash` has priority over everything:
  - next state is IDLE, `rs_gnt`=0 that cycle;
  - the operand and result valid bits are cleared, `cdb_req`=0 the next cycle;
  - `rr_ptr` is kept.
  - `squash` and `cdb_gnt` in the same cycle: the broadcast completes (the CDB consumed it) and the FSM still goes to IDLE.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0;
  - `rs_gnt` 0, `cdb_req` 0, `cdb_tag` 0, `cdb_taken` 0, `cdb_redirect_pc` 0, `cdb_mispredict` 0, `busy` 0.
- Latency: grant in cycle t, EXEC in t+1, `cdb_req` high from t+2.
- Throughput: one branch per 2 cycles with `cdb_gnt` always high.
- Result outputs are stable while `cdb_req`=1 && !`cdb_gnt`.
- `reset` mid-operation drops in-flight branches silently.

## Configuration
- `BRANCH_STATS_EN` defined:
  - adds 32-bit saturating outputs `stat_resolved` and `stat_mispredict`;
  - each increments on a `cdb_req` && `cdb_gnt` cycle, `stat_mispredict` only when `cdb_mispredict`=1;
  - reset to 0; unaffected by `squash`.
- `BRANCH_STATS_EN` undefined: the ports and counters do not exist.

## Structure
- Shared package / `sys_defs.svh`:
  - `XLEN`;
  - `BR_FUNC` enum for the funct3 codes;
  - `BR_CTRL_STATE` enum (IDLE, EXEC, BCAST);
  - `BR_RESULT` struct (tag, taken, redirect_pc, mispredict).
- Sub-modules:
  - `rr_arbiter` (N-way round-robin: req, ptr in → one-hot gnt, next ptr out);
  - one existing `branch_unit` instance for condition and target.

## Test plan
- Reset, then `rs_req`=0 → all outputs 0, `busy`=0, no grant.
- Entry 2 only: BEQ rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 → gnt=0100 at t, `cdb_req` at t+2: taken=1, redirect=0x120, mispredict=0.
- All 4 requesting, `cdb_gnt` always 1 → grants 0,1,2,3,0 every 2 cycles. BLT rs1=0xFFFFFFFF, rs2=1 → taken. BLTU on the same operands → not taken, redirect=pc+4.
- `cdb_gnt` held low 5 cycles → `cdb_req` and all result fields constant, no new grant. Then `cdb_gnt` with a pending request → new grant the same cycle.
- `squash` during EXEC → next cycle IDLE, `cdb_req`=0. `squash`+`cdb_gnt` in BCAST → IDLE, no grant.
- BNE pred_taken=0, rs1≠rs2, pc=0xFFFFFFF0, imm=0x20 → taken, redirect=0x10 (wrap), mispredict=1. With `BRANCH_STATS_EN` → `stat_mispredict` increments by 1.
